// File: rtl/error_resp_sched_if.sv
// Handshake bundle linking the error-response scheduler to the response generator and the transmit path.
// Header width defaults to SIZE_OF_HEADER_VARS * SIZE_OF_HEADER_IN_BYTES unless those macros are predefined.
`ifndef SIZE_OF_HEADER_VARS
`define SIZE_OF_HEADER_VARS 4
`endif
`ifndef SIZE_OF_HEADER_IN_BYTES
`define SIZE_OF_HEADER_IN_BYTES 8
`endif

interface error_resp_sched_if #(
  parameter int unsigned HW = `SIZE_OF_HEADER_VARS * `SIZE_OF_HEADER_IN_BYTES
);
  logic          resp_enable;
  logic [4:0]    resp_error;
  logic          resp_msg_ready;
  logic [HW-1:0] resp_header;
  logic          tx_valid;
  logic [HW-1:0] tx_header;
  logic          tx_ready;

  // master = scheduler side, slave = generator plus transmit path
  modport master (
    output resp_enable, resp_error, tx_valid, tx_header,
    input  resp_msg_ready, resp_header, tx_ready
  );
  modport slave (
    input  resp_enable, resp_error, tx_valid, tx_header,
    output resp_msg_ready, resp_header, tx_ready
  );
endinterface

// File: rtl/error_resp_sched.sv
// Error-response scheduler: queues error events, drives the generator one error at a time, hands headers to TX.
// Optional busy timeout on req_active/req_done is enabled by defining ERR_SCHED_BUSY_TIMEOUT_EN.
module error_resp_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned GEN_WDOG       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         err_req_in,
  input  logic               req_active,
  input  logic               req_done,
  error_resp_sched_if.master bus,
  output logic [4:0]         pending,
  output logic               overflow,
  output logic               gen_fault
);

  typedef enum logic [1:0] {IDLE, GEN, SEND} state_t;

  state_t     state_reg;
  logic [4:0] cur_sel_reg;
  logic [3:0] wdog_cnt_reg;
  logic [4:0] pending_reg;
  logic [4:0] pending_next;
  logic       overflow_reg;
  logic       gen_fault_reg;

  logic [4:0] pick_sel;
  logic       start_gen;
  logic       wdog_expire;
  logic       busy_evt;
  logic [4:0] event_vec;
  logic [4:0] set_vec;
  logic [4:0] clr_vec;
  logic       ovf_hit;

  // One-hot of the highest set bit; bit 4 has top priority.
  function automatic logic [4:0] prio_sel(input logic [4:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  assign pick_sel    = prio_sel(pending_reg);
  assign start_gen   = (state_reg == IDLE) && (pending_reg != 5'd0);
  assign wdog_expire = (state_reg == GEN) && !bus.resp_msg_ready &&
                       (wdog_cnt_reg == 4'(GEN_WDOG - 1));

`ifdef ERR_SCHED_BUSY_TIMEOUT_EN
  logic [15:0] busy_cnt_reg;
  logic        busy_run;

  assign busy_run = req_active && !req_done;
  assign busy_evt = busy_run && (busy_cnt_reg == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_cnt_reg <= '0;
    end else if (!busy_run || busy_evt) begin
      busy_cnt_reg <= '0;
    end else begin
      busy_cnt_reg <= busy_cnt_reg + 16'd1;
    end
  end
`else
  assign busy_evt = 1'b0;
  wire unused_busy_inputs = ^{req_active, req_done, 16'(TIMEOUT_CYCLES)};
`endif

  // A timeout is treated exactly like an external Busy pulse, including the overflow rule.
  assign event_vec = err_req_in | {2'b00, busy_evt, 2'b00};
  assign set_vec   = event_vec | (wdog_expire ? cur_sel_reg : 5'd0);
  assign clr_vec   = start_gen ? pick_sel : 5'd0;
  assign ovf_hit   = |(event_vec & pending_reg);

  // Set has priority over clear for every bit.
  for (genvar gi = 0; gi < 5; gi++) begin : g_pend
    assign pending_next[gi] = set_vec[gi] | (pending_reg[gi] & ~clr_vec[gi]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      if (ovf_hit) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      cur_sel_reg     <= '0;
      wdog_cnt_reg    <= '0;
      gen_fault_reg   <= 1'b0;
      bus.resp_enable <= 1'b0;
      bus.resp_error  <= '0;
      bus.tx_valid    <= 1'b0;
      bus.tx_header   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_gen) begin
            state_reg       <= GEN;
            cur_sel_reg     <= pick_sel;
            wdog_cnt_reg    <= '0;
            bus.resp_enable <= 1'b1;
            bus.resp_error  <= pick_sel;
          end
        end
        GEN: begin
          if (bus.resp_msg_ready) begin
            state_reg       <= SEND;
            bus.tx_header   <= bus.resp_header;
            bus.tx_valid    <= 1'b1;
            bus.resp_enable <= 1'b0;
            bus.resp_error  <= '0;
          end else if (wdog_expire) begin
            // Generator stalled: give up, the pending bit is restored for a later retry.
            state_reg       <= IDLE;
            gen_fault_reg   <= 1'b1;
            bus.resp_enable <= 1'b0;
            bus.resp_error  <= '0;
          end else begin
            wdog_cnt_reg <= wdog_cnt_reg + 4'd1;
          end
        end
        SEND: begin
          if (bus.tx_ready) begin
            state_reg    <= IDLE;
            bus.tx_valid <= 1'b0;
          end
        end
        default: begin
          state_reg       <= IDLE;
          bus.resp_enable <= 1'b0;
          bus.resp_error  <= '0;
          bus.tx_valid    <= 1'b0;
        end
      endcase
    end
  end

  assign pending   = pending_reg;
  assign overflow  = overflow_reg;
  assign gen_fault = gen_fault_reg;

endmodule

// File: tb/tb_error_resp_sched.sv
// Directed bench for error_resp_sched: latency, priority, overflow, watchdog, busy timeout and reset abort.
`ifndef SIZE_OF_HEADER_VARS
`define SIZE_OF_HEADER_VARS 4
`endif
`ifndef SIZE_OF_HEADER_IN_BYTES
`define SIZE_OF_HEADER_IN_BYTES 8
`endif

module tb_error_resp_sched;
  localparam int HW = `SIZE_OF_HEADER_VARS * `SIZE_OF_HEADER_IN_BYTES;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] err_req_in = '0;
  logic       req_active = 1'b0;
  logic       req_done = 1'b0;
  logic [4:0] pending;
  logic       overflow;
  logic       gen_fault;

  logic       gen_auto = 1'b1;
  logic       gen_lat = 1'b0;
  logic       gen_en_d = 1'b0;
  logic       tx_rdy = 1'b1;

  int n_cmp = 0;
  int n_err = 0;
  logic [HW-1:0] tx_log[$];

  error_resp_sched_if #(.HW(HW)) bus ();

  error_resp_sched #(.TIMEOUT_CYCLES(10), .GEN_WDOG(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .err_req_in (err_req_in),
    .req_active (req_active),
    .req_done   (req_done),
    .bus        (bus.master),
    .pending    (pending),
    .overflow   (overflow),
    .gen_fault  (gen_fault)
  );

  always #5 clk = ~clk;

  // Generator model: ready either with Enable or one cycle later; header tagged with the selected error.
  always @(posedge clk) gen_en_d <= bus.resp_enable;
  assign bus.resp_msg_ready = gen_auto & bus.resp_enable & (~gen_lat | gen_en_d);
  assign bus.resp_header    = HW'(32'hC0DE_0000 | 32'(bus.resp_error));
  assign bus.tx_ready       = tx_rdy;

  always @(negedge clk) begin
    if (!reset && bus.tx_valid && tx_rdy) begin
      tx_log.push_back(bus.tx_header);
      $display("tx #%0d header=%h t=%0t", tx_log.size(), bus.tx_header, $time);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [4:0] v);
    err_req_in = v;
    tick();
    err_req_in = '0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.tx_valid && n < 50) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.tx_valid), 32'd1);
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < tx_log.size()) return 32'(tx_log[i]);
    return 32'hFFFF_FFFF;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_pending",  32'(pending), 32'h0);
    chk("rst_enable",   32'(bus.resp_enable), 32'h0);
    chk("rst_txvalid",  32'(bus.tx_valid), 32'h0);
    chk("rst_txheader", 32'(bus.tx_header), 32'h0);
    chk("rst_flags",    32'({overflow, gen_fault}), 32'h0);
    reset = 1'b0;
    tick();

    // Single Busy event, immediate ready: GEN at 2, SEND at 3, IDLE at 4
    gen_lat = 1'b0; tx_rdy = 1'b1; tx_log.delete();
    pulse(5'b00100);
    chk("t1_c1_pending", 32'(pending), 32'h04);
    chk("t1_c1_enable",  32'(bus.resp_enable), 32'h0);
    tick();
    chk("t1_c2_enable",  32'(bus.resp_enable), 32'h1);
    chk("t1_c2_error",   32'(bus.resp_error), 32'h04);
    chk("t1_c2_pending", 32'(pending), 32'h0);
    tick();
    chk("t1_c3_txvalid", 32'(bus.tx_valid), 32'h1);
    chk("t1_c3_enable",  32'(bus.resp_enable), 32'h0);
    chk("t1_c3_header",  32'(bus.tx_header), 32'hC0DE_0004);
    tick();
    chk("t1_c4_txvalid", 32'(bus.tx_valid), 32'h0);
    chk("t1_count",      32'(tx_log.size()), 32'd1);

    // Priority order with a one-cycle-late generator
    gen_lat = 1'b1; tx_log.delete();
    pulse(5'b10011);
    chk("t2_pending", 32'(pending), 32'h13);
    repeat (30) tick();
    chk("t2_count", 32'(tx_log.size()), 32'd3);
    chk("t2_first",  log_at(0), 32'hC0DE_0010);
    chk("t2_second", log_at(1), 32'hC0DE_0002);
    chk("t2_third",  log_at(2), 32'hC0DE_0001);
    chk("t2_overflow", 32'(overflow), 32'h0);
    chk("t2_pending_end", 32'(pending), 32'h0);

    // Overflow while held in SEND
    gen_lat = 1'b0; tx_rdy = 1'b0; tx_log.delete();
    pulse(5'b00001);
    wait_valid("t3_reach_send");
    pulse(5'b00001);
    chk("t3_inflight_pending", 32'(pending), 32'h01);
    chk("t3_inflight_noovf",   32'(overflow), 32'h0);
    pulse(5'b00001);
    chk("t3_overflow", 32'(overflow), 32'h1);
    chk("t3_pending",  32'(pending), 32'h01);
    tx_rdy = 1'b1;
    repeat (12) tick();
    chk("t3_count", 32'(tx_log.size()), 32'd2);
    chk("t3_hdr0", log_at(0), 32'hC0DE_0001);
    chk("t3_hdr1", log_at(1), 32'hC0DE_0001);
    chk("t3_pending_end", 32'(pending), 32'h0);

    // Watchdog: generator never ready
    reset = 1'b1;
    tick();
    chk("t4_rst_ovf", 32'(overflow), 32'h0);
    reset = 1'b0;
    tick();
    gen_auto = 1'b0; tx_log.delete();
    pulse(5'b01000);
    tick();
    repeat (7) tick();
    chk("t4_c9_enable", 32'(bus.resp_enable), 32'h1);
    chk("t4_c9_fault",  32'(gen_fault), 32'h0);
    tick();
    chk("t4_c10_enable",  32'(bus.resp_enable), 32'h0);
    chk("t4_c10_fault",   32'(gen_fault), 32'h1);
    chk("t4_c10_pending", 32'(pending), 32'h08);
    tick();
    chk("t4_c11_enable", 32'(bus.resp_enable), 32'h1);
    chk("t4_c11_error",  32'(bus.resp_error), 32'h08);
    gen_auto = 1'b1;
    repeat (6) tick();
    chk("t4_count", 32'(tx_log.size()), 32'd1);
    chk("t4_hdr",   log_at(0), 32'hC0DE_0008);
    chk("t4_fault_sticky", 32'(gen_fault), 32'h1);

    // Busy timeout
    tx_log.delete();
`ifdef ERR_SCHED_BUSY_TIMEOUT_EN
    req_active = 1'b1;
    repeat (9) tick();
    chk("t5_c9_pending",  32'(pending), 32'h0);
    tick();
    chk("t5_c10_pending", 32'(pending), 32'h04);
    req_active = 1'b0;
    repeat (10) tick();
    chk("t5_count", 32'(tx_log.size()), 32'd1);
`else
    begin
      logic seen;
      seen = 1'b0;
      req_active = 1'b1;
      repeat (30) begin
        tick();
        if (pending != 5'd0 || bus.resp_enable) seen = 1'b1;
      end
      req_active = 1'b0;
      chk("t5_no_timeout", 32'(seen), 32'h0);
      chk("t5_count", 32'(tx_log.size()), 32'd0);
    end
`endif

    // Reset while stalled in SEND abandons the message
    tx_rdy = 1'b0; tx_log.delete();
    pulse(5'b00010);
    wait_valid("t6_reach_send");
    pulse(5'b00001);
    chk("t6_pending_pre", 32'(pending), 32'h01);
    reset = 1'b1;
    #1;
    chk("t6_txvalid_now", 32'(bus.tx_valid), 32'h0);
    chk("t6_pending_now", 32'(pending), 32'h0);
    tick();
    reset = 1'b0;
    tx_rdy = 1'b1;
    repeat (15) tick();
    chk("t6_count",   32'(tx_log.size()), 32'd0);
    chk("t6_txvalid", 32'(bus.tx_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
